// File: rtl/jt08_pkg.sv
// Shared constants for the jt08 rhythm ADPCM key-on/dump sequencer and its slot ring.
package jt08_pkg;

  localparam int              NCH          = 6;
  localparam logic [7:0]      RHY_KEY_ADDR = 8'h10;
  localparam int              DUMP_BIT     = 7;
  localparam logic [NCH-1:0]  RING_RST     = 6'b000001;

  // Advance a one-hot slot vector to the next channel, wrapping the top bit to bit 0.
  function automatic logic [NCH-1:0] ring_rotl(input logic [NCH-1:0] v);
    return {v[NCH-2:0], v[NCH-1]};
  endfunction

endpackage

// File: rtl/jt08_rhythm_keyctl_if.sv
// CPU key-register bus plus the sequencer outputs seen by the address counter.
// Carries the status byte when JT08_RHY_STATUS_EN is defined.
interface jt08_rhythm_keyctl_if;
  import jt08_pkg::*;

  // wr_key is a one-clk strobe with no ready: the register always accepts a
  // write, and din is sampled only on clocks where wr_key is 1.
  logic [7:0]     din;
  logic           wr_key;
  logic [NCH-1:0] cur_ch;
  logic [NCH-1:0] en_ch;
  logic           aon;
  logic           aoff;
  logic [NCH-1:0] pend;
`ifdef JT08_RHY_STATUS_EN
  logic [7:0]     status;
`endif

  modport master (
    output din, wr_key,
    input  cur_ch, en_ch, aon, aoff, pend
`ifdef JT08_RHY_STATUS_EN
    , input status
`endif
  );

  modport slave (
    input  din, wr_key,
    output cur_ch, en_ch, aon, aoff, pend
`ifdef JT08_RHY_STATUS_EN
    , output status
`endif
  );

endinterface

// File: rtl/jt08_rhythm_ring.sv
// One-hot channel slot ring: advances one slot per cen and exposes the next slot
// so callers can act on the slot being entered in the same edge.
module jt08_rhythm_ring
  import jt08_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           cen,
  output logic [NCH-1:0] cur_o,
  output logic [NCH-1:0] nxt_o
);

  logic [NCH-1:0] cur_q;
  logic [NCH-1:0] cur_d;

  always_comb begin
    nxt_o = ring_rotl(cur_q);
    cur_d = cur_q;
    if (cen) cur_d = nxt_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_q <= RING_RST;
    else     cur_q <= cur_d;
  end

  assign cur_o = cur_q;

endmodule

// File: rtl/jt08_rhythm_keyctl.sv
// Rhythm key-on/dump sequencer: turns key-register writes into per-channel requests
// issued once in each channel's slot. JT08_RHY_STATUS_EN adds a registered status byte.
module jt08_rhythm_keyctl
  import jt08_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cen,
  jt08_rhythm_keyctl_if.slave  bus
);

  logic [NCH-1:0] cur_ch;
  logic [NCH-1:0] nxt_ch;

  logic [NCH-1:0] pend_on_q,  pend_on_d;
  logic [NCH-1:0] pend_off_q, pend_off_d;
  logic [NCH-1:0] en_q,       en_d;
  logic           aon_q,      aon_d;
  logic           aoff_q,     aoff_d;

  logic [NCH-1:0] wr_mask;
  logic [NCH-1:0] iss_on;
  logic [NCH-1:0] iss_off;
  logic           unused_din6;

  assign unused_din6 = bus.din[6];

  jt08_rhythm_ring u_ring (
    .clk   (clk),
    .rst   (rst),
    .cen   (cen),
    .cur_o (cur_ch),
    .nxt_o (nxt_ch)
  );

  always_comb begin
    wr_mask = bus.wr_key ? bus.din[NCH-1:0] : '0;
    iss_on  = '0;
    iss_off = '0;
    // A write to the slot being entered takes priority over that slot's issue.
    if (cen) begin
      iss_on  = pend_on_q  & nxt_ch & ~wr_mask;
      iss_off = pend_off_q & nxt_ch & ~wr_mask;
    end

    pend_on_d  = pend_on_q  & ~iss_on;
    pend_off_d = pend_off_q & ~iss_off;
    if (bus.din[DUMP_BIT]) begin
      pend_off_d = pend_off_d |  wr_mask;
      pend_on_d  = pend_on_d  & ~wr_mask;
    end else begin
      pend_on_d  = pend_on_d  |  wr_mask;
      pend_off_d = pend_off_d & ~wr_mask;
    end

    en_d   = en_q;
    aon_d  = aon_q;
    aoff_d = aoff_q;
    if (cen) begin
      aon_d  = |iss_on;
      aoff_d = |iss_off;
      if (aon_d)  en_d = en_d |  nxt_ch;
      if (aoff_d) en_d = en_d & ~nxt_ch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_on_q  <= '0;
      pend_off_q <= '0;
      en_q       <= '0;
      aon_q      <= 1'b0;
      aoff_q     <= 1'b0;
    end else begin
      pend_on_q  <= pend_on_d;
      pend_off_q <= pend_off_d;
      en_q       <= en_d;
      aon_q      <= aon_d;
      aoff_q     <= aoff_d;
    end
  end

  assign bus.cur_ch = cur_ch;
  assign bus.en_ch  = en_q;
  assign bus.aon    = aon_q;
  assign bus.aoff   = aoff_q;
  assign bus.pend   = pend_on_q | pend_off_q;

`ifdef JT08_RHY_STATUS_EN
  logic [7:0] status_q;
  logic [7:0] status_d;

  always_comb begin
    status_d = {|(pend_on_q | pend_off_q), 1'b0, en_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) status_q <= '0;
    else     status_q <= status_d;
  end

  assign bus.status = status_q;
`endif

endmodule

// File: tb/tb_jt08_rhythm_keyctl.sv
// Directed and random bench for jt08_rhythm_keyctl against a per-channel request model.
module tb_jt08_rhythm_keyctl;
  import jt08_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic cen;

  jt08_rhythm_keyctl_if bus ();

  jt08_rhythm_keyctl dut (
    .clk (clk),
    .rst (rst),
    .cen (cen),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  // kind: 0 = nothing pending, 1 = key-on pending, 2 = dump pending
  int         slot;
  int         kind [6];
  logic [5:0] en_m;
  logic       aon_m;
  logic       aoff_m;

  function automatic void model_reset();
    slot   = 0;
    en_m   = '0;
    aon_m  = 1'b0;
    aoff_m = 1'b0;
    for (int i = 0; i < 6; i++) kind[i] = 0;
  endfunction

  function automatic void model_edge(input logic c, input logic w, input logic [7:0] d);
    int ns;
    if (c) begin
      ns     = (slot + 1) % 6;
      aon_m  = (kind[ns] == 1) && !(w && d[ns]);
      aoff_m = (kind[ns] == 2) && !(w && d[ns]);
      if (aon_m)  begin kind[ns] = 0; en_m[ns] = 1'b1; end
      if (aoff_m) begin kind[ns] = 0; en_m[ns] = 1'b0; end
      slot = ns;
    end
    if (w) begin
      for (int i = 0; i < 6; i++)
        if (d[i]) kind[i] = d[7] ? 2 : 1;
    end
  endfunction

  function automatic logic [5:0] model_pend();
    logic [5:0] p;
    p = '0;
    for (int i = 0; i < 6; i++) p[i] = (kind[i] != 0);
    return p;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_state(input string tag);
    logic [19:0] obs;
    logic [19:0] exp;
    logic [5:0]  cur_exp;
    cur_exp = 6'(1 << slot);
    obs = {bus.cur_ch, bus.en_ch, bus.aon, bus.aoff, bus.pend};
    exp = {cur_exp, en_m, aon_m, aoff_m, model_pend()};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: {cur,en,aon,aoff,pend} observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input logic c, input logic w, input logic [7:0] d, input string tag);
    @(negedge clk);
    cen        = c;
    bus.wr_key = w;
    bus.din    = d;
    @(posedge clk);
    model_edge(c, w, d);
    #1 check_state(tag);
  endtask

  task automatic do_cen(input int gap, input string tag);
    repeat (gap) tick(1'b0, 1'b0, 8'h00, tag);
    tick(1'b1, 1'b0, 8'h00, tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    cen        = 1'b0;
    bus.wr_key = 1'b0;
    bus.din    = 8'h00;
    #2 rst = 1'b1;
    model_reset();
    #1 check_state(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    cen        = 1'b0;
    bus.wr_key = 1'b0;
    bus.din    = 8'h00;
    model_reset();
    #1 check_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // ring walk with no requests
    for (int i = 0; i < 12; i++) do_cen(1, "ring_walk");

    // single key-on written while cur_ch = 04
    do_cen(0, "to_slot2");
    do_cen(1, "to_slot2");
    check_val("cur_before_wr", {2'b00, bus.cur_ch}, 8'h04);
    tick(1'b0, 1'b1, 8'h01, "wr_01");
    for (int i = 0; i < 4; i++) do_cen(2, "keyon_ch0");
    check_val("aon_ch0", {7'b0, bus.aon}, 8'h01);
    check_val("en_after_01", {2'b00, bus.en_ch}, 8'h01);
    check_val("pend_after_01", {2'b00, bus.pend}, 8'h00);

    // all channels keyed on
    tick(1'b0, 1'b1, 8'h3F, "wr_3f");
    for (int i = 0; i < 6; i++) do_cen(1, "keyon_all");
    check_val("en_after_3f", {2'b00, bus.en_ch}, 8'h3F);

    // dump channels 0 and 2
    tick(1'b0, 1'b1, 8'h85, "wr_85");
    for (int i = 0; i < 6; i++) do_cen(1, "dump_0_2");
    check_val("en_after_85", {2'b00, bus.en_ch}, 8'h3A);

    // collision: key-on write lands on the cen entering slot 1 with a dump pending
    tick(1'b0, 1'b1, 8'h82, "wr_82");
    tick(1'b1, 1'b1, 8'h02, "collide");
    check_val("collide_aoff", {6'b0, bus.aon, bus.aoff}, 8'h00);
    for (int i = 0; i < 6; i++) do_cen(1, "after_collide");
    check_val("aon_slot1_pass2", {bus.aon, 1'b0, bus.cur_ch}, 8'h82);

    // reset with requests pending
    tick(1'b0, 1'b1, 8'h30, "wr_30");
    check_val("pend_30", {2'b00, bus.pend}, 8'h30);
    do_reset("mid_reset");
    for (int i = 0; i < 8; i++) do_cen(1, "post_reset");

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset("rand_reset");
      tick(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 4) == 0),
           8'($urandom), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
